// File: rtl/uart_tx_framed_if.sv
// Word handshake between the TX data source and uart_tx_framed: valid/ready plus per-word
// data and framing configuration.
interface uart_tx_framed_if #(
   parameter int DATA_BITS = 8
);
   logic                 i_valid;
   logic                 o_ready;
   logic [DATA_BITS-1:0] i_data;
   logic [1:0]           i_parity_mode;
   logic                 i_two_stop;

   modport master (
      output i_valid,
      output i_data,
      output i_parity_mode,
      output i_two_stop,
      input  o_ready
   );

   modport slave (
      input  i_valid,
      input  i_data,
      input  i_parity_mode,
      input  i_two_stop,
      output o_ready
   );
endinterface

// File: rtl/uart_tx_framed.sv
// Parametrised UART transmitter: configurable width/oversampling, per-frame parity and stop
// bits, and a one-word holding buffer so consecutive frames leave no idle gap on the line.
module uart_tx_framed #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_bd_tick,
   uart_tx_framed_if.slave     io_bus,
   output logic                o_tx,
   output logic                o_busy,
   output logic                o_tx_done
);

   localparam int TW = $clog2(2 * OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);

   localparam logic [TW-1:0] BIT_LAST   = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] STOP2_LAST = TW'(2 * OVERSAMPLE - 1);
   localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_BITS - 1);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   logic [2:0]           r_state;
   logic [TW-1:0]        r_tick_cnt;
   logic [BW-1:0]        r_bit_cnt;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par_bit;
   logic                 r_has_par;
   logic                 r_two_stop;

   logic                 r_hold_full;
   logic [DATA_BITS-1:0] r_hold_data;
   logic [1:0]           r_hold_mode;
   logic                 r_hold_two;

   logic                 r_tx;
   logic                 r_done;

   logic                 w_bit_end;
   logic [TW-1:0]        w_stop_last;
   logic                 w_frame_end;
   logic                 w_load;
   logic                 w_accept;
   logic                 w_hold_par_en;
   logic                 w_hold_par_bit;
   logic                 w_tx_next;

   assign w_bit_end      = i_bd_tick & (r_tick_cnt == BIT_LAST);
   assign w_stop_last    = r_two_stop ? STOP2_LAST : BIT_LAST;
   assign w_frame_end    = (r_state == ST_STOP) & i_bd_tick & (r_tick_cnt == w_stop_last);
   // Loading at frame end chains the next START directly after the last stop tick.
   assign w_load         = r_hold_full & ((r_state == ST_IDLE) | w_frame_end);
   assign w_accept       = io_bus.i_valid & ~r_hold_full;
   assign w_hold_par_en  = (r_hold_mode == 2'b01) | (r_hold_mode == 2'b10);
   assign w_hold_par_bit = (r_hold_mode == 2'b10) ? ~^r_hold_data : ^r_hold_data;

   always_comb begin
      w_tx_next = 1'b1;
      case (r_state)
         ST_START:  w_tx_next = 1'b0;
         ST_DATA:   w_tx_next = r_shift[0];
         ST_PARITY: w_tx_next = r_par_bit;
         default:   w_tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= ST_IDLE;
         r_tick_cnt  <= '0;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_par_bit   <= 1'b0;
         r_has_par   <= 1'b0;
         r_two_stop  <= 1'b0;
         r_hold_full <= 1'b0;
         r_hold_data <= '0;
         r_hold_mode <= '0;
         r_hold_two  <= 1'b0;
         r_tx        <= 1'b1;
         r_done      <= 1'b0;
      end else begin
         r_tx   <= w_tx_next;
         r_done <= w_frame_end;

         if (w_load) begin
            r_hold_full <= 1'b0;
         end else if (w_accept) begin
            r_hold_full <= 1'b1;
            r_hold_data <= io_bus.i_data;
            r_hold_mode <= io_bus.i_parity_mode;
            r_hold_two  <= io_bus.i_two_stop;
         end

         if (w_load) begin
            r_shift    <= r_hold_data;
            r_par_bit  <= w_hold_par_bit;
            r_has_par  <= w_hold_par_en;
            r_two_stop <= r_hold_two;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_state    <= ST_START;
         end else if (i_bd_tick) begin
            case (r_state)
               ST_START: begin
                  if (w_bit_end) begin
                     r_tick_cnt <= '0;
                     r_bit_cnt  <= '0;
                     r_state    <= ST_DATA;
                  end else begin
                     r_tick_cnt <= r_tick_cnt + TW'(1);
                  end
               end
               ST_DATA: begin
                  if (w_bit_end) begin
                     r_tick_cnt <= '0;
                     r_shift    <= r_shift >> 1;
                     if (r_bit_cnt == DATA_LAST) begin
                        r_state <= r_has_par ? ST_PARITY : ST_STOP;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + BW'(1);
                     end
                  end else begin
                     r_tick_cnt <= r_tick_cnt + TW'(1);
                  end
               end
               ST_PARITY: begin
                  if (w_bit_end) begin
                     r_tick_cnt <= '0;
                     r_state    <= ST_STOP;
                  end else begin
                     r_tick_cnt <= r_tick_cnt + TW'(1);
                  end
               end
               ST_STOP: begin
                  if (w_frame_end) begin
                     r_tick_cnt <= '0;
                     r_state    <= ST_IDLE;
                  end else begin
                     r_tick_cnt <= r_tick_cnt + TW'(1);
                  end
               end
               ST_IDLE: begin
                  r_tick_cnt <= r_tick_cnt;
               end
               default: begin
                  r_tick_cnt <= '0;
                  r_state    <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign io_bus.o_ready = ~r_hold_full;
   assign o_tx           = r_tx;
   assign o_tx_done      = r_done;
   assign o_busy         = (r_state != ST_IDLE) | r_hold_full;

endmodule

// File: tb/tb_uart_tx_framed.sv
// Directed bench for uart_tx_framed (DATA_BITS=8, OVERSAMPLE=16): frames are checked cycle by
// cycle against hand-written bit sequences {stop(s), [parity], data, start}.
module tb_uart_tx_framed;

   logic i_clk;
   logic i_reset;
   logic i_bd_tick;
   logic o_tx;
   logic o_busy;
   logic o_tx_done;

   int unsigned n_tests;
   int unsigned n_fail;
   int unsigned done_cnt;
   int unsigned tick_per;
   int unsigned tick_phase;

   uart_tx_framed_if #(.DATA_BITS(8)) bus_if ();

   uart_tx_framed #(
      .DATA_BITS  (8),
      .OVERSAMPLE (16)
   ) dut (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_bd_tick (i_bd_tick),
      .io_bus    (bus_if.slave),
      .o_tx      (o_tx),
      .o_busy    (o_busy),
      .o_tx_done (o_tx_done)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      tick_phase = 0;
      i_bd_tick  = 1'b1;
   end

   always @(negedge i_clk) begin
      i_bd_tick  = (tick_phase == 0);
      tick_phase = (tick_phase + 1 >= tick_per) ? 0 : tick_phase + 1;
   end

   always @(posedge i_clk) begin
      if (o_tx_done === 1'b1) done_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] d, input logic [1:0] pm, input logic two);
      int unsigned k;
      k = 0;
      while (bus_if.o_ready !== 1'b1 && k < 2000) begin
         @(negedge i_clk);
         k++;
      end
      chk("send_ready", bus_if.o_ready, 1);
      bus_if.i_data        = d;
      bus_if.i_parity_mode = pm;
      bus_if.i_two_stop    = two;
      bus_if.i_valid       = 1'b1;
      @(negedge i_clk);
      bus_if.i_valid       = 1'b0;
   endtask

   // Waits for the start bit, then samples every cycle of each bit; o_tx_done must be high
   // only on the final cycle of the last stop bit.
   task automatic check_frame(input string tag, input logic [15:0] bits, input int unsigned nb,
                              input int unsigned cpb, input bit skip_start,
                              output int unsigned gap);
      logic [63:0] vtx, vdn, etx, edn;
      int unsigned k, first;
      k = 0;
      @(negedge i_clk);
      while (o_tx !== 1'b0 && k < 400) begin
         @(negedge i_clk);
         k++;
      end
      gap = k;
      chk({tag, "_start"}, o_tx, 0);
      if (o_tx !== 1'b0) return;
      first = 0;
      if (skip_start) begin
         k = 0;
         while (o_tx !== 1'b1 && k < 200) begin
            @(negedge i_clk);
            k++;
         end
         first = 1;
      end
      for (int unsigned b = first; b < nb; b++) begin
         vtx = '0;
         vdn = '0;
         for (int unsigned c = 0; c < cpb; c++) begin
            if (b != first || c != 0) @(negedge i_clk);
            vtx[c] = o_tx;
            vdn[c] = o_tx_done;
         end
         etx = bits[b] ? ((64'd1 << cpb) - 64'd1) : 64'd0;
         edn = (b == nb - 1) ? (64'd1 << (cpb - 1)) : 64'd0;
         chk($sformatf("%s_bit%0d_tx", tag, b), vtx, etx);
         chk($sformatf("%s_bit%0d_done", tag, b), vdn, edn);
      end
   endtask

   initial begin
      int unsigned gap, gap2, gap3, d0;
      logic [7:0] words [3];
      n_tests  = 0;
      n_fail   = 0;
      done_cnt = 0;
      tick_per = 1;
      i_reset  = 1'b1;
      bus_if.i_valid       = 1'b0;
      bus_if.i_data        = '0;
      bus_if.i_parity_mode = '0;
      bus_if.i_two_stop    = 1'b0;
      repeat (3) @(negedge i_clk);
      chk("rst_tx", o_tx, 1);
      chk("rst_ready", bus_if.o_ready, 1);
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_tx_done, 0);
      i_reset = 1'b0;
      @(negedge i_clk);

      // 8N1 0x55 with acceptance latency
      d0 = done_cnt;
      send(8'h55, 2'b00, 1'b0);
      chk("t1_ready_drop", bus_if.o_ready, 0);
      chk("t1_busy", o_busy, 1);
      chk("t1_tx_idle", o_tx, 1);
      check_frame("t1", {1'b1, 8'h55, 1'b0}, 10, 16, 1'b0, gap);
      chk("t1_gap", gap, 1);
      @(negedge i_clk);
      chk("t1_tx_high", o_tx, 1);
      chk("t1_busy_end", o_busy, 0);
      chk("t1_done_cnt", done_cnt - d0, 1);

      // parity modes
      send(8'hA3, 2'b01, 1'b0);
      check_frame("t2_even", {1'b1, 1'b0, 8'hA3, 1'b0}, 11, 16, 1'b0, gap);
      send(8'hA3, 2'b10, 1'b0);
      check_frame("t2_odd", {1'b1, 1'b1, 8'hA3, 1'b0}, 11, 16, 1'b0, gap);
      send(8'h01, 2'b01, 1'b0);
      check_frame("t2_even01", {1'b1, 1'b1, 8'h01, 1'b0}, 11, 16, 1'b0, gap);
      send(8'hA3, 2'b11, 1'b0);
      check_frame("t2_m11", {1'b1, 8'hA3, 1'b0}, 10, 16, 1'b0, gap);
      @(negedge i_clk);
      chk("t2_m11_idle_tx", o_tx, 1);
      chk("t2_m11_idle_busy", o_busy, 0);

      // two stop bits
      send(8'h00, 2'b00, 1'b1);
      check_frame("t3", {2'b11, 8'h00, 1'b0}, 11, 16, 1'b0, gap);

      // back-to-back with i_valid held
      d0 = done_cnt;
      words[0] = 8'h11;
      words[1] = 8'h22;
      words[2] = 8'h33;
      @(negedge i_clk);
      fork
         begin
            for (int w = 0; w < 3; w++) begin
               int unsigned k;
               bus_if.i_data        = words[w];
               bus_if.i_parity_mode = 2'b00;
               bus_if.i_two_stop    = 1'b0;
               bus_if.i_valid       = 1'b1;
               k = 0;
               while (bus_if.o_ready !== 1'b1 && k < 2000) begin
                  @(negedge i_clk);
                  k++;
               end
               @(posedge i_clk);
               @(negedge i_clk);
               chk($sformatf("t4_ready_drop%0d", w), bus_if.o_ready, 0);
            end
            bus_if.i_valid = 1'b0;
         end
         begin
            check_frame("t4_f1", {1'b1, 8'h11, 1'b0}, 10, 16, 1'b0, gap);
            check_frame("t4_f2", {1'b1, 8'h22, 1'b0}, 10, 16, 1'b0, gap2);
            check_frame("t4_f3", {1'b1, 8'h33, 1'b0}, 10, 16, 1'b0, gap3);
            chk("t4_gap2", gap2, 0);
            chk("t4_gap3", gap3, 0);
         end
      join
      chk("t4_done_cnt", done_cnt - d0, 3);

      // ticks every 4 cycles
      tick_per = 4;
      send(8'h55, 2'b00, 1'b0);
      check_frame("t5", {1'b1, 8'h55, 1'b0}, 10, 64, 1'b1, gap);
      tick_per = 1;
      repeat (4) @(negedge i_clk);

      // reset mid-frame with hold full
      send(8'hF0, 2'b00, 1'b0);
      send(8'hAA, 2'b00, 1'b0);
      repeat (40) @(negedge i_clk);
      chk("t6_tx_pre", o_tx, 0);
      chk("t6_busy_pre", o_busy, 1);
      chk("t6_ready_pre", bus_if.o_ready, 0);
      d0 = done_cnt;
      i_reset = 1'b1;
      @(negedge i_clk);
      chk("t6_tx", o_tx, 1);
      chk("t6_ready", bus_if.o_ready, 1);
      chk("t6_busy", o_busy, 0);
      chk("t6_done", o_tx_done, 0);
      i_reset = 1'b0;
      repeat (30) @(negedge i_clk);
      chk("t6_tx_quiet", o_tx, 1);
      chk("t6_busy_quiet", o_busy, 0);
      chk("t6_no_done", done_cnt - d0, 0);
      send(8'h3C, 2'b00, 1'b0);
      check_frame("t6_after", {1'b1, 8'h3C, 1'b0}, 10, 16, 1'b0, gap);
      @(negedge i_clk);
      chk("t6_done_cnt", done_cnt - d0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
